// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared cache types and block width for the memory arbiter
package mem_arbiter_pkg;
  localparam int CACHE_BLOCK_SIZE = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} arb_state_t;
  typedef enum logic [1:0] {SRC_DC_WB, SRC_DC_RD, SRC_IC_RD} mem_src_t;
  typedef struct packed {
    logic                        valid;
    logic [31:0]                 addr;
    logic [CACHE_BLOCK_SIZE-1:0] data;
  } mem_slot_t;
endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: single-entry capture of a request pulse with sticky overflow flag
module mem_req_slot
  import mem_arbiter_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        vld_i,
  input  logic [31:0]                 addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] data_i,
  input  logic                        clr_i,
  output mem_slot_t                   slot_o,
  output logic                        rdy_o,
  output logic                        ovf_o
);
  assign rdy_o = !slot_o.valid;
  // a pulse in the grant cycle still sees the slot full and is dropped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_o <= '0;
      ovf_o  <= 1'b0;
    end else begin
      if (clr_i) slot_o.valid <= 1'b0;
      else if (vld_i && !slot_o.valid) slot_o <= '{valid: 1'b1, addr: addr_i, data: data_i};
      if (vld_i && slot_o.valid) ovf_o <= 1'b1;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences I-cache/D-cache reads and D-cache writebacks onto one memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ic_req_vld_i,
  input  logic [31:0]                 ic_req_addr_i,
  output logic                        ic_req_rdy_o,
  output logic                        ic_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] ic_resp_data_o,
  input  logic                        dc_req_vld_i,
  input  logic [31:0]                 dc_req_addr_i,
  output logic                        dc_req_rdy_o,
  output logic                        dc_resp_vld_o,
  output logic [CACHE_BLOCK_SIZE-1:0] dc_resp_data_o,
  input  logic                        dc_wb_vld_i,
  input  logic [31:0]                 dc_wb_addr_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] dc_wb_data_i,
  output logic                        dc_wb_rdy_o,
  output logic                        mem_req_vld_o,
  input  logic                        mem_req_rdy_i,
  output logic                        mem_req_we_o,
  output logic [31:0]                 mem_req_addr_o,
  output logic [CACHE_BLOCK_SIZE-1:0] mem_req_data_o,
  input  logic                        mem_resp_vld_i,
  input  logic [CACHE_BLOCK_SIZE-1:0] mem_resp_data_i,
  output logic                        err_overflow_o
);
  arb_state_t state;
  mem_src_t   src, sel;
  mem_slot_t  wb_s, dc_s, ic_s, g;
  logic       rr_ptr, any, grant;
  logic [2:0] ovf;
  mem_req_slot u_wb (.clk_i, .rst_i, .vld_i(dc_wb_vld_i), .addr_i(dc_wb_addr_i), .data_i(dc_wb_data_i),
                     .clr_i(grant && sel == SRC_DC_WB), .slot_o(wb_s), .rdy_o(dc_wb_rdy_o), .ovf_o(ovf[0]));
  mem_req_slot u_dc (.clk_i, .rst_i, .vld_i(dc_req_vld_i), .addr_i(dc_req_addr_i), .data_i('0),
                     .clr_i(grant && sel == SRC_DC_RD), .slot_o(dc_s), .rdy_o(dc_req_rdy_o), .ovf_o(ovf[1]));
  mem_req_slot u_ic (.clk_i, .rst_i, .vld_i(ic_req_vld_i), .addr_i(ic_req_addr_i), .data_i('0),
                     .clr_i(grant && sel == SRC_IC_RD), .slot_o(ic_s), .rdy_o(ic_req_rdy_o), .ovf_o(ovf[2]));
  assign err_overflow_o = |ovf;
  // writeback first keeps a later read of the same block from overtaking it
  always_comb begin
    any   = wb_s.valid || dc_s.valid || ic_s.valid;
    grant = state == IDLE && any;
    sel   = wb_s.valid ? SRC_DC_WB :
            (dc_s.valid && ic_s.valid) ? (rr_ptr ? SRC_IC_RD : SRC_DC_RD) :
            dc_s.valid ? SRC_DC_RD : SRC_IC_RD;
    g     = sel == SRC_DC_WB ? wb_s : sel == SRC_DC_RD ? dc_s : ic_s;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      src            <= SRC_DC_WB;
      rr_ptr         <= 1'b0;
      mem_req_vld_o  <= 1'b0;
      mem_req_we_o   <= 1'b0;
      mem_req_addr_o <= '0;
      mem_req_data_o <= '0;
      ic_resp_vld_o  <= 1'b0;
      ic_resp_data_o <= '0;
      dc_resp_vld_o  <= 1'b0;
      dc_resp_data_o <= '0;
    end else begin
      ic_resp_vld_o <= 1'b0;
      dc_resp_vld_o <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          state          <= ISSUE;
          src            <= sel;
          mem_req_vld_o  <= 1'b1;
          mem_req_we_o   <= sel == SRC_DC_WB;
          mem_req_addr_o <= g.addr;
          mem_req_data_o <= g.data;
          if (sel != SRC_DC_WB) rr_ptr <= sel == SRC_DC_RD;
        end
        ISSUE: if (mem_req_rdy_i) begin
          mem_req_vld_o <= 1'b0;
          state         <= mem_req_we_o ? IDLE : WAIT_RESP;
        end
        WAIT_RESP: if (mem_resp_vld_i) begin
          state <= IDLE;
          if (src == SRC_IC_RD) begin
            ic_resp_vld_o  <= 1'b1;
            ic_resp_data_o <= mem_resp_data_i;
          end else begin
            dc_resp_vld_o  <= 1'b1;
            dc_resp_data_o <= mem_resp_data_i;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cycle-exact checks of slot capture, priority, round-robin and reset
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic                        clk_i = 1'b0, rst_i = 1'b1;
  logic                        ic_req_vld_i = 1'b0, dc_req_vld_i = 1'b0, dc_wb_vld_i = 1'b0;
  logic [31:0]                 ic_req_addr_i = '0, dc_req_addr_i = '0, dc_wb_addr_i = '0;
  logic [CACHE_BLOCK_SIZE-1:0] dc_wb_data_i = '0, mem_resp_data_i = '0;
  logic                        mem_req_rdy_i = 1'b0, mem_resp_vld_i = 1'b0;
  logic                        ic_req_rdy_o, ic_resp_vld_o, dc_req_rdy_o, dc_resp_vld_o, dc_wb_rdy_o;
  logic                        mem_req_vld_o, mem_req_we_o, err_overflow_o;
  logic [31:0]                 mem_req_addr_o;
  logic [CACHE_BLOCK_SIZE-1:0] ic_resp_data_o, dc_resp_data_o, mem_req_data_o;
  int n_cmp = 0, n_err = 0;
  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_req_vld_i(ic_req_vld_i), .ic_req_addr_i(ic_req_addr_i), .ic_req_rdy_o(ic_req_rdy_o),
    .ic_resp_vld_o(ic_resp_vld_o), .ic_resp_data_o(ic_resp_data_o),
    .dc_req_vld_i(dc_req_vld_i), .dc_req_addr_i(dc_req_addr_i), .dc_req_rdy_o(dc_req_rdy_o),
    .dc_resp_vld_o(dc_resp_vld_o), .dc_resp_data_o(dc_resp_data_o),
    .dc_wb_vld_i(dc_wb_vld_i), .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
    .dc_wb_rdy_o(dc_wb_rdy_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_resp_vld_i(mem_resp_vld_i), .mem_resp_data_i(mem_resp_data_i),
    .err_overflow_o(err_overflow_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [CACHE_BLOCK_SIZE-1:0] obs, input logic [CACHE_BLOCK_SIZE-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mvld"}, mem_req_vld_o, 1'b0);
    chk({tag, "_mwe"}, mem_req_we_o, 1'b0);
    chk({tag, "_maddr"}, mem_req_addr_o, 0);
    chk({tag, "_mdata"}, mem_req_data_o, 0);
    chk({tag, "_icvld"}, ic_resp_vld_o, 1'b0);
    chk({tag, "_dcvld"}, dc_resp_vld_o, 1'b0);
    chk({tag, "_icdata"}, ic_resp_data_o, 0);
    chk({tag, "_dcdata"}, dc_resp_data_o, 0);
    chk({tag, "_icrdy"}, ic_req_rdy_o, 1'b1);
    chk({tag, "_dcrdy"}, dc_req_rdy_o, 1'b1);
    chk({tag, "_wbrdy"}, dc_wb_rdy_o, 1'b1);
    chk({tag, "_err"}, err_overflow_o, 1'b0);
  endtask
  // entered in the cycle a read request is expected on memory; leaves in the response cycle + 1
  task automatic serve_read(input string tag, input logic [31:0] a, input logic [CACHE_BLOCK_SIZE-1:0] d, input logic is_ic);
    chk({tag, "_mvld"}, mem_req_vld_o, 1'b1);
    chk({tag, "_mwe"}, mem_req_we_o, 1'b0);
    chk({tag, "_maddr"}, mem_req_addr_o, a);
    mem_req_rdy_i = 1'b1;
    cyc();
    mem_req_rdy_i = 1'b0;
    chk({tag, "_mvld_drop"}, mem_req_vld_o, 1'b0);
    mem_resp_vld_i = 1'b1;
    mem_resp_data_i = d;
    cyc();
    mem_resp_vld_i = 1'b0;
    chk({tag, "_icvld"}, ic_resp_vld_o, is_ic);
    chk({tag, "_dcvld"}, dc_resp_vld_o, !is_ic);
    chk({tag, "_rdata"}, is_ic ? ic_resp_data_o : dc_resp_data_o, d);
  endtask
  initial begin
    cyc();
    cyc();
    chk_idle_outputs("rst");
    rst_i = 1'b0;
    // single DC read
    dc_req_vld_i = 1'b1; dc_req_addr_i = 32'h0000_1040;
    cyc();
    dc_req_vld_i = 1'b0;
    chk("rd1_dcrdy_busy", dc_req_rdy_o, 1'b0);
    chk("rd1_mvld_early", mem_req_vld_o, 1'b0);
    cyc();
    chk("rd1_dcrdy_free", dc_req_rdy_o, 1'b1);
    serve_read("rd1", 32'h0000_1040, {8{8'hA5}}, 1'b0);
    cyc();
    chk("rd1_dcvld_pulse", dc_resp_vld_o, 1'b0);
    chk("rd1_dcdata_hold", dc_resp_data_o, {8{8'hA5}});
    chk("rd1_icdata", ic_resp_data_o, 0);
    // writeback beats a simultaneous read
    dc_wb_vld_i = 1'b1; dc_wb_addr_i = 32'h2000; dc_wb_data_i = 64'h1111_2222_3333_4444;
    dc_req_vld_i = 1'b1; dc_req_addr_i = 32'h3000;
    cyc();
    dc_wb_vld_i = 1'b0; dc_req_vld_i = 1'b0;
    chk("wb_wbrdy_busy", dc_wb_rdy_o, 1'b0);
    chk("wb_dcrdy_busy", dc_req_rdy_o, 1'b0);
    cyc();
    chk("wb_mvld", mem_req_vld_o, 1'b1);
    chk("wb_mwe", mem_req_we_o, 1'b1);
    chk("wb_maddr", mem_req_addr_o, 32'h2000);
    chk("wb_mdata", mem_req_data_o, 64'h1111_2222_3333_4444);
    chk("wb_wbrdy_free", dc_wb_rdy_o, 1'b1);
    chk("wb_dcrdy_still", dc_req_rdy_o, 1'b0);
    mem_req_rdy_i = 1'b1;
    cyc();
    mem_req_rdy_i = 1'b0;
    chk("wb_mvld_drop", mem_req_vld_o, 1'b0);
    cyc();
    serve_read("wb_rd", 32'h3000, 64'h0123_4567_89AB_CDEF, 1'b0);
    // round-robin from reset: DC, IC, DC, IC
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      ic_req_vld_i = 1'b1; ic_req_addr_i = 32'h4000 + 32'(r * 'h100);
      dc_req_vld_i = 1'b1; dc_req_addr_i = 32'h5000 + 32'(r * 'h100);
      cyc();
      ic_req_vld_i = 1'b0; dc_req_vld_i = 1'b0;
      cyc();
      serve_read($sformatf("rr%0d_dc", r), 32'h5000 + 32'(r * 'h100), 64'hD000 + 64'(r), 1'b0);
      cyc();
      serve_read($sformatf("rr%0d_ic", r), 32'h4000 + 32'(r * 'h100), 64'hE000 + 64'(r), 1'b1);
      chk($sformatf("rr%0d_dcdata_hold", r), dc_resp_data_o, 64'hD000 + 64'(r));
    end
    // backpressure on a writeback
    dc_wb_vld_i = 1'b1; dc_wb_addr_i = 32'h6000; dc_wb_data_i = 64'hBEEF_0000_CAFE_F00D;
    cyc();
    dc_wb_vld_i = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_mvld", i), mem_req_vld_o, 1'b1);
      chk($sformatf("bp%0d_maddr", i), mem_req_addr_o, 32'h6000);
      chk($sformatf("bp%0d_mdata", i), mem_req_data_o, 64'hBEEF_0000_CAFE_F00D);
      cyc();
    end
    chk("bp_mvld_hold", mem_req_vld_o, 1'b1);
    mem_req_rdy_i = 1'b1;
    cyc();
    mem_req_rdy_i = 1'b0;
    chk("bp_mvld_drop", mem_req_vld_o, 1'b0);
    // overflow: second IC pulse lands in the grant cycle while the slot is still full
    ic_req_vld_i = 1'b1; ic_req_addr_i = 32'h7000;
    cyc();
    ic_req_addr_i = 32'h7100;
    chk("ovf_err_before", err_overflow_o, 1'b0);
    cyc();
    ic_req_vld_i = 1'b0;
    chk("ovf_err_set", err_overflow_o, 1'b1);
    serve_read("ovf", 32'h7000, 64'h7777, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("ovf%0d_no_second", i), mem_req_vld_o, 1'b0);
      chk($sformatf("ovf%0d_sticky", i), err_overflow_o, 1'b1);
    end
    // reset during WAIT_RESP followed by a stray response
    dc_req_vld_i = 1'b1; dc_req_addr_i = 32'h8000;
    cyc();
    dc_req_vld_i = 1'b0;
    cyc();
    chk("rw_mvld", mem_req_vld_o, 1'b1);
    mem_req_rdy_i = 1'b1;
    cyc();
    mem_req_rdy_i = 1'b0;
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    mem_resp_vld_i = 1'b1; mem_resp_data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    cyc();
    mem_resp_vld_i = 1'b0;
    chk_idle_outputs("rw");
    cyc();
    chk_idle_outputs("rw2");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single main-memory port between the I-cache refill path and the D-cache controller. The D-cache controller issues refill reads and dirty-eviction writebacks. Single-cycle request pulses from each source are captured in per-source slots, and one transaction is sequenced to memory at a time. Read responses are routed back to the requester that issued them. The block sits between the cache controllers and the main-memory model/interface.

## Interface
- CACHE_BLOCK_SIZE, from shared cache package, block width in bits (memory data width)
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- ic_req_vld_i  in  1  I-cache refill read pulse
- ic_req_addr_i  in  32  I-cache refill address
- ic_req_rdy_o  out  1  I-cache read slot empty
- ic_resp_vld_o  out  1  I-cache refill data valid (1-cycle pulse)
- ic_resp_data_o  out  CACHE_BLOCK_SIZE  I-cache refill block
- dc_req_vld_i  in  1  D-cache refill read pulse (driven by controller mem_req_vld_o)
- dc_req_addr_i  in  32  D-cache refill address
- dc_req_rdy_o  out  1  D-cache read slot empty
- dc_resp_vld_o  out  1  D-cache refill data valid (1-cycle pulse)
- dc_resp_data_o  out  CACHE_BLOCK_SIZE  D-cache refill block
- dc_wb_vld_i  in  1  D-cache writeback pulse
- dc_wb_addr_i  in  32  writeback block address
- dc_wb_data_i  in  CACHE_BLOCK_SIZE  evicted block
- dc_wb_rdy_o  out  1  writeback slot empty
- mem_req_vld_o  out  1  memory request valid
- mem_req_rdy_i  in  1  memory accepts request
- mem_req_we_o  out  1  1 = write, 0 = read
- mem_req_addr_o  out  32  memory address
- mem_req_data_o  out  CACHE_BLOCK_SIZE  write data
- mem_resp_vld_i  in  1  read data valid
- mem_resp_data_i  in  CACHE_BLOCK_SIZE  read data
- err_overflow_o  out  1  sticky: pulse arrived at a full slot

## Operation
- Three slots (DC_WB, DC_RD, IC_RD), each holding valid, addr, and data (data for WB only).
- A pulse on a slot's input sets the slot's valid bit and captures its fields.
- A slot's rdy output is the inverse of its valid bit.
- A pulse while the slot is valid is dropped and sets err_overflow_o, which stays set until reset.
- FSM states: IDLE, ISSUE, WAIT_RESP.
- IDLE: if any slot is valid, grant one slot and copy its fields into the issue registers. Clear that slot's valid bit and go to ISSUE. The slot accepts a new pulse from the next cycle.
- Grant priority: DC_WB first, so a writeback always precedes any later read of the same block.
- Reads are arbitrated round-robin on rr_ptr (0 = DC, 1 = IC). If both reads are pending, grant the source rr_ptr points to, then point rr_ptr at the other source.
- If only one read is pending, grant it and point rr_ptr at the other source.
- ISSUE: hold mem_req_vld_o = 1 with addr/we/data stable until mem_req_rdy_i = 1.
  - On acceptance of a write, go to IDLE.
  - On acceptance of a read, go to WAIT_RESP.
- WAIT_RESP: on mem_resp_vld_i, register the data into the granted source's resp_data register, pulse its resp_vld for one cycle, and go to IDLE.
- resp_data holds its value until that source's next response.
- mem_resp_vld_i outside WAIT_RESP is ignored.
- Only one memory transaction is outstanding at a time.

## Timing
- Reset values:
  - All slot valid bits = 0; all rdy outputs = 1.
  - mem_req_vld_o = 0, mem_req_we_o = 0, mem_req_addr_o = 0, mem_req_data_o = 0.
  - Both resp_vld outputs = 0; both resp_data outputs = 0.
  - err_overflow_o = 0; rr_ptr = 0; FSM = IDLE.
- Request latency: pulse in cycle T → slot valid in T+1 → grant in T+1 (IDLE) → mem_req_vld_o = 1 in T+2.
- Response latency: mem_resp_vld_i in cycle R → resp_vld pulse in R+1, FSM = IDLE in R+1 → next mem_req_vld_o no earlier than R+2.
- Write: accepted in cycle A → next mem_req_vld_o no earlier than A+2.
- Back-to-back pulses from the same source: a second pulse is accepted in the grant cycle + 1 at the earliest.
- Simultaneous pulses on all three slots: all three are captured in the same cycle. Issue order is WB, then the read rr_ptr points to, then the other read.
- Reset mid-transaction:
  - Everything returns to reset values and the in-flight transaction is abandoned.
  - A late mem_resp_vld_i is ignored (FSM = IDLE).
  - The memory side must tolerate an abandoned request.

## Structure
- Shared cache package:
  - CACHE_BLOCK_SIZE.
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT_RESP}.
  - typedef enum mem_src_t {SRC_DC_WB, SRC_DC_RD, SRC_IC_RD}.
  - typedef struct mem_slot_t {valid, addr, data}.
- Sub-module mem_req_slot: capture register with valid, rdy, clear, and overflow flag, instantiated three times. The top level holds the FSM, priority/round-robin logic, issue registers and response routing.

## Test plan
- Single DC read: dc pulse addr 0x0000_1040 at T; rdy = 1 at T+2; resp data 0xA5.. at R → mem_req addr 0x1040, we = 0 at T+2; dc_resp_vld_o at R+1 with 0xA5..; ic_resp_vld_o stays 0.
- WB priority: dc_wb (addr 0x2000) and dc_req (addr 0x3000) pulse in the same cycle → mem sees write 0x2000 first, then read 0x3000; dc_wb_rdy_o returns to 1 the cycle after the WB grant.
- Round-robin: IC and DC reads pending together, twice, from reset → order DC, IC, then DC, IC; each response goes only to its issuer.
- Backpressure: mem_req_rdy_i held 0 for 5 cycles → mem_req_vld_o and addr/data stable throughout; the transaction completes once rdy = 1.
- Overflow: second ic pulse while IC slot is valid → err_overflow_o = 1 and sticky; the second address never appears on memory.
- Reset during WAIT_RESP, then a stray mem_resp_vld_i → no resp_vld pulse; all outputs at reset values.
